// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings and NOP word.
// CK_HI/CK_LO exist only when IMEM_LOADER_CKSUM_EN is defined.
package imem_loader_pkg;

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    CK_HI = 3'd3,
    CK_LO = 3'd4,
    DONE  = 3'd5
  } ld_state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    DONE = 3'd5
  } ld_state_e;
`endif

  localparam logic [15:0] NOP_INSN = 16'h0000;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_ram.sv
// 2**AW x DW instruction RAM: synchronous write, asynchronous read (read-during-write sees old data).
module imem_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM plus byte-stream program loader; holds the CPU disabled during a load.
// Optional trailer checksum check enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_datain,
  input  logic          load_start,
  input  logic [AW-1:0] load_len,
  imem_loader_if.slave  strm,
  output logic          busy,
  output logic          load_done,
  output logic          cpu_enable,
  output logic          cksum_err
);

  ld_state_e     state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    hi_q, hi_d;
  logic          busy_q, busy_d;
  logic          cpu_en_q, cpu_en_d;
  logic          ready_c;
  logic          we_c;
  logic [DW-1:0] word_c;

  assign word_c = {hi_q, strm.in_data};

  // Acceptance is keyed on in_valid per state (ready is 1 there) to avoid a ready->accept loop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    hi_d      = hi_q;
    ready_c   = 1'b0;
    we_c      = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          cnt_d   = (load_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, load_len};
          waddr_d = '0;
          state_d = HI;
        end
      end
      HI: begin
        ready_c = 1'b1;
        if (strm.in_valid) begin
          hi_d    = strm.in_data;
          state_d = LO;
        end
      end
      LO: begin
        ready_c = 1'b1;
        if (strm.in_valid) begin
          we_c    = 1'b1;
          waddr_d = waddr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == (AW+1)'(1)) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = CK_HI;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = HI;
          end
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CK_HI: begin
        ready_c = 1'b1;
        if (strm.in_valid) begin
          hi_d    = strm.in_data;
          state_d = CK_LO;
        end
      end
      CK_LO: begin
        ready_c = 1'b1;
        if (strm.in_valid) state_d = DONE;
      end
`endif
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    cpu_en_d = ~busy_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      cpu_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      cpu_en_q <= cpu_en_d;
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  logic        cksum_err_q, cksum_err_d;

  always_comb begin
    cksum_d     = cksum_q;
    cksum_err_d = cksum_err_q;
    if (state_q == IDLE && load_start) begin
      cksum_d     = '0;
      cksum_err_d = 1'b0;
    end
    if (state_q == LO && strm.in_valid) cksum_d = cksum_q + word_c;
    if (state_q == CK_LO && strm.in_valid && word_c != cksum_q) cksum_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cksum_q     <= '0;
      cksum_err_q <= 1'b0;
    end else begin
      cksum_q     <= cksum_d;
      cksum_err_q <= cksum_err_d;
    end
  end

  assign cksum_err = cksum_err_q;
`else
  assign cksum_err = 1'b0;
`endif

  assign strm.in_ready = ready_c;
  assign busy          = busy_q;
  assign cpu_enable    = cpu_en_q;

  imem_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clock),
    .we    (we_c),
    .waddr (waddr_q),
    .wdata (word_c),
    .raddr (i_addr),
    .rdata (i_datain)
  );

endmodule
